// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: streams one frame-buffer frame to the OLED SPI byte controller, one page at a time
module oled_frame_streamer #(
    parameter int PAGES  = 4,
    parameter int COLS   = 128,
    parameter int ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    output logic              SPI_EN,
    output logic [7:0]        SPI_DATA,
    input  logic              SPI_FIN,
    output logic              DC
);
    localparam int PW = PAGES > 1 ? $clog2(PAGES) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CMD_LOAD = 3'd1;
    localparam logic [2:0] MEM_RD   = 3'd2;
    localparam logic [2:0] MEM_WAIT = 3'd3;
    localparam logic [2:0] SEND     = 3'd4;
    localparam logic [2:0] RELEASE  = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;
    logic [2:0]        state;
    logic [PW-1:0]     page;
    logic [CW-1:0]     col;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] page_base;
    logic [7:0]        cmd_byte;
    always_comb begin
        page_base = ADDR_W'(int'(page) * COLS);
        cmd_byte  = idx == 2'd0 ? (8'hB0 | 8'(page)) : idx == 2'd1 ? 8'h00 : 8'h10;
    end
    // DC doubles as the phase flag: low while sending the address command, high for pixel data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            page     <= '0;
            col      <= '0;
            idx      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            MEM_ADDR <= '0;
            SPI_EN   <= 1'b0;
            SPI_DATA <= '0;
            DC       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    state <= CMD_LOAD;
                    page  <= '0;
                    idx   <= '0;
                    BUSY  <= 1'b1;
                end
                CMD_LOAD: begin
                    SPI_DATA <= cmd_byte;
                    DC       <= 1'b0;
                    state    <= SEND;
                end
                MEM_RD: state <= MEM_WAIT;
                MEM_WAIT: begin
                    SPI_DATA <= MEM_DATA;
                    DC       <= 1'b1;
                    state    <= SEND;
                end
                // SPI_EN rises one cycle after the byte is loaded so data leads the request
                SEND: if (SPI_EN && SPI_FIN) begin
                    SPI_EN <= 1'b0;
                    state  <= RELEASE;
                end else begin
                    SPI_EN <= 1'b1;
                end
                RELEASE: if (!SPI_FIN) begin
                    if (!DC) begin
                        if (idx != 2'd2) begin
                            idx   <= idx + 2'd1;
                            state <= CMD_LOAD;
                        end else begin
                            col      <= '0;
                            MEM_ADDR <= page_base;
                            state    <= MEM_RD;
                        end
                    end else if (col != CW'(COLS - 1)) begin
                        col      <= col + 1'b1;
                        MEM_ADDR <= MEM_ADDR + 1'b1;
                        state    <= MEM_RD;
                    end else if (page != PW'(PAGES - 1)) begin
                        page  <= page + 1'b1;
                        idx   <= '0;
                        state <= CMD_LOAD;
                    end else begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/oled_frame_streamer.md
Name: oled_frame_streamer

Overview:
- Upstream feeder for the OLED SPI byte controller. It streams one full frame from the display frame-buffer RAM to the panel.
- For each page it sends a 3-byte page/column address command sequence with DC low, then COLS data bytes with DC high.
- It drives the byte controller's enable/data/finish handshake, one byte at a time.
- It sits between the frame-buffer RAM read port and the SPI controller.

Parameters:
- PAGES, 4, number of display pages (8-pixel rows) per frame.
- COLS, 128, data bytes per page.
- ADDR_W, 9, frame-buffer address width; must satisfy 2^ADDR_W >= PAGES*COLS.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request to stream one frame; ignored while BUSY=1.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse after the last byte of the frame has been released.
- MEM_ADDR  out  ADDR_W  frame-buffer read address = page*COLS + col.
- MEM_DATA  in  8  frame-buffer read data, valid exactly 1 cycle after MEM_ADDR.
- SPI_EN  out  1  byte-send request to the SPI controller.
- SPI_DATA  out  8  byte to send; stable whenever SPI_EN=1.
- SPI_FIN  in  1  SPI controller completion flag; stays high until SPI_EN drops.
- DC  out  1  OLED data/command select (0 = command, 1 = data); stable whenever SPI_EN=1.

Behaviour:
- Reset (async, any state): state=IDLE; SPI_EN=0, SPI_DATA=0, DC=0, BUSY=0, DONE=0, MEM_ADDR=0; page and byte counters cleared.
- IDLE: START=1 -> CMD_LOAD, page=0, idx=0. BUSY rises on the next edge.
- CMD_LOAD:
  - DC=0.
  - SPI_DATA = idx0: 0xB0|page, idx1: 0x00 (column low), idx2: 0x10 (column high).
  - Next state is SEND. SPI_DATA is valid at least one full cycle before SPI_EN rises.
- MEM_RD: MEM_ADDR = page*COLS + col -> MEM_WAIT.
- MEM_WAIT: capture MEM_DATA into SPI_DATA, DC=1 -> SEND.
- SEND:
  - SPI_EN=1 and held.
  - SPI_FIN=1 -> RELEASE, and SPI_EN drops on that same edge.
- RELEASE:
  - SPI_EN=0; wait for SPI_FIN=0.
  - Then advance the counters:
    - Command phase: idx<2 -> idx+1, CMD_LOAD. idx==2 -> col=0, MEM_RD.
    - Data phase: col<COLS-1 -> col+1, MEM_RD. col==COLS-1 and page<PAGES-1 -> page+1, idx=0, CMD_LOAD. Otherwise -> FINISH.
- FINISH: DONE=1 for exactly one cycle, BUSY=0 on the same edge -> IDLE.
- DC and SPI_DATA change only in CMD_LOAD/MEM_WAIT, never while SPI_EN=1 or SPI_FIN=1.
- Counter widths: col is clog2(COLS) bits and page is clog2(PAGES) bits; neither counter may wrap before its terminal compare.
- START while BUSY: ignored, no queuing. START in the same cycle as DONE: ignored; a new START is accepted only in IDLE.
- SPI_FIN high while in IDLE or CMD_LOAD (stale): no effect. Only SEND and RELEASE observe SPI_FIN.
- Reset mid-frame drops SPI_EN immediately. The SPI controller's own reset must accompany it; no partial-frame resume.
- Frame byte count = PAGES*(3+COLS) = 524 for the defaults.
- Minimum per-byte overhead beyond the SPI controller's time: 1 cycle (command) or 2 cycles (data) before SPI_EN rises, plus 1 RELEASE cycle.

Test Plan:
- Single frame, behavioural SPI model (SPI_FIN 20 cycles after SPI_EN, low 1 cycle after SPI_EN drops), RAM[a]=a[7:0]:
  - Exactly 524 bytes are sent.
  - Sequence begins B0,00,10 with DC=0, then 00..7F with DC=1.
  - Page 1 begins B1,00,10, then 80..FF.
  - DONE pulses once; BUSY is low afterwards.
- Handshake integrity: check every cycle that SPI_DATA and DC do not change while SPI_EN=1 or SPI_FIN=1, and that SPI_EN never rises while SPI_FIN=1.
- RAM latency: RAM returns 0xA5 only at address 0x1FF and 0 elsewhere -> the final byte is A5 with DC=1, and no other byte is A5.
- START pulses at byte 10 and in the DONE cycle -> ignored, and exactly 524 bytes are sent. A START 2 cycles after DONE -> a second full frame.
- Async RST asserted mid-SEND on page 2 -> SPI_EN, BUSY and DC are 0 before the next clock edge. After release, START -> the frame restarts at B0.
- Slow SPI model (SPI_FIN deasserts 5 cycles after SPI_EN drops) -> the FSM holds in RELEASE, no byte is skipped, and the count is still 524.
